// File: rtl/smem_output_writer_if.sv
// Bundle of the result-store and host-write handshake signals for smem_output_writer.
// The slave modport is the writer itself; master is whatever drives and consumes it.
interface smem_output_writer_if;
  logic         start;
  logic [57:0]  base_addr;
  logic         output_request;
  logic         output_permit;
  logic [511:0] output_data;
  logic         output_valid;
  logic         output_finish;
  logic         stall;
  logic         wr_req_valid;
  logic [57:0]  wr_req_addr;
  logic [511:0] wr_req_data;
  logic         wr_req_ready;
  logic         done;
  logic [31:0]  lines_written;
  logic         overflow;

  modport master (
    output start, base_addr, output_request, output_data, output_valid,
           output_finish, wr_req_ready,
    input  output_permit, stall, wr_req_valid, wr_req_addr, wr_req_data,
           done, lines_written, overflow
  );

  modport slave (
    input  start, base_addr, output_request, output_data, output_valid,
           output_finish, wr_req_ready,
    output output_permit, stall, wr_req_valid, wr_req_addr, wr_req_data,
           done, lines_written, overflow
  );
endinterface

// File: rtl/smem_output_writer.sv
// Buffers result lines from the result store in a show-ahead FIFO and issues them as
// sequential cache-line host writes from a per-batch base address.
module smem_output_writer #(
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_THRESH = 12
) (
  input logic                 clk,
  input logic                 reset,
  smem_output_writer_if.slave bus
);
  localparam int DATA_W = 512;
  localparam int ADDR_W = 58;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REQ = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] line_idx;
  logic [31:0]       lines_cnt;
  logic              ovf_q;
  logic              stall_q;
  logic              permit;
  logic              done_pulse;

  logic empty;
  logic full;
  logic accepting;
  logic push;
  logic pop;
  logic push_ok;
  logic batch_start;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign accepting   = (state == STREAM) || (state == DRAIN);
  assign push        = accepting && bus.output_valid;
  assign pop         = !empty && bus.wr_req_ready;
  // A full FIFO still takes a line when the head leaves in the same cycle.
  assign push_ok     = push && (!full || pop);
  assign batch_start = (state == IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.start)          state_nxt = WAIT_REQ;
      WAIT_REQ: if (bus.output_request) state_nxt = STREAM;
      STREAM:   if (bus.output_finish)  state_nxt = DRAIN;
      DRAIN:    if (empty && !push)     state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    permit     = 1'b0;
    done_pulse = 1'b0;
    case (state)
      STREAM, DRAIN: permit     = 1'b1;
      DONE:          done_pulse = 1'b1;
      default: ;
    endcase
  end

  // Line storage carries data only and is left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.output_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Registered from current occupancy; threshold leaves headroom for the in-flight line.
      stall_q <= (count >= THRESH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      line_idx  <= '0;
      lines_cnt <= '0;
      ovf_q     <= 1'b0;
    end else if (batch_start) begin
      base_q    <= bus.base_addr;
      line_idx  <= '0;
      lines_cnt <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (pop) begin
        line_idx  <= line_idx + ADDR_W'(1);
        lines_cnt <= lines_cnt + 32'd1;
      end
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.output_permit = permit;
  assign bus.done          = done_pulse;
  assign bus.stall         = stall_q;
  assign bus.wr_req_valid  = !empty;
  assign bus.wr_req_data   = mem[rd_ptr];
  assign bus.wr_req_addr   = base_q + line_idx;
  assign bus.lines_written = lines_cnt;
  assign bus.overflow      = ovf_q;
endmodule

// File: tb/tb_smem_output_writer.sv
// Directed bench for smem_output_writer: table of batch scenarios plus a mid-batch reset sequence.
module tb_smem_output_writer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  smem_output_writer_if bus();

  smem_output_writer #(
    .FIFO_DEPTH  (16),
    .STALL_THRESH(12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [57:0] base;
    int          nlines;
    bit          hold_ready;
    bit          fin_with_last;
    bit          restart_mid;
    int          exp_written;
    bit          exp_ov;
    logic [57:0] exp_last_addr;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  logic [57:0]  wq[$];
  logic [511:0] dq[$];
  int           done_cnt = 0;
  bit           mon_en   = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] line_data(input int v, input int k);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = {8'(v), 8'(k), 8'(j), 8'hC3};
    return d;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.wr_req_valid && bus.wr_req_ready) begin
        wq.push_back(bus.wr_req_addr);
        dq.push_back(bus.wr_req_data);
      end
      if (bus.done) begin
        done_cnt++;
        check("done_with_fifo_empty", 512'(bus.wr_req_valid), 512'(1'b0));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_permit"},  512'(bus.output_permit), '0);
    check({tag, "_stall"},   512'(bus.stall),         '0);
    check({tag, "_wvalid"},  512'(bus.wr_req_valid),  '0);
    check({tag, "_done"},    512'(bus.done),          '0);
    check({tag, "_ovf"},     512'(bus.overflow),      '0);
    check({tag, "_lines"},   512'(bus.lines_written), '0);
    check({tag, "_addr"},    512'(bus.wr_req_addr),   '0);
  endtask

  task automatic run_batch(input int v);
    vec_t        t;
    int          p;
    int          occ;
    int          cyc;
    logic        exp_stall;
    logic [57:0] ea;
    t = vecs[v];
    wq.delete();
    dq.delete();
    done_cnt = 0;
    mon_en   = 1'b1;

    bus.start        = 1'b1;
    bus.base_addr    = t.base;
    bus.wr_req_ready = !t.hold_ready;
    @(posedge clk); #1;
    bus.start          = 1'b0;
    bus.output_request = 1'b1;
    cyc = 0;
    while (!bus.output_permit && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d_permit", v), 512'(bus.output_permit), 512'(1'b1));
    bus.output_request = 1'b0;

    for (int k = 0; k < t.nlines; k++) begin
      bus.output_valid  = 1'b1;
      bus.output_data   = line_data(v, k);
      bus.output_finish = t.fin_with_last && (k == t.nlines - 1);
      if (t.restart_mid && k == 1) begin
        bus.start     = 1'b1;
        bus.base_addr = 58'h3DEAD;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      p = k + 1;
      exp_stall = t.hold_ready && (((p - 1) > 16 ? 16 : (p - 1)) >= 12);
      check($sformatf("v%0d_stall_push%0d", v, p), 512'(bus.stall), 512'(exp_stall));
    end
    bus.output_valid  = 1'b0;
    bus.output_finish = 1'b1;
    @(posedge clk); #1;
    check($sformatf("v%0d_overflow_after_push", v), 512'(bus.overflow), 512'(t.exp_ov));

    if (t.hold_ready) begin
      check($sformatf("v%0d_valid_held", v), 512'(bus.wr_req_valid), 512'(1'b1));
      occ = (t.nlines > 16) ? 16 : t.nlines;
      bus.wr_req_ready = 1'b1;
      for (int e = 1; e <= occ - 9; e++) begin
        @(posedge clk); #1;
        exp_stall = ((occ - (e - 1)) >= 12);
        check($sformatf("v%0d_stall_drain%0d", v, e), 512'(bus.stall), 512'(exp_stall));
      end
    end

    cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("v%0d_done_seen", v), 512'(done_cnt > 0), 512'(1'b1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.output_finish = 1'b0;
    check($sformatf("v%0d_done_pulses", v),   512'(done_cnt),          512'(1));
    check($sformatf("v%0d_lines_written", v), 512'(bus.lines_written), 512'(t.exp_written));
    check($sformatf("v%0d_overflow", v),      512'(bus.overflow),      512'(t.exp_ov));
    check($sformatf("v%0d_write_count", v),   512'(wq.size()),         512'(t.exp_written));
    for (int k = 0; k < wq.size() && k < t.exp_written; k++) begin
      ea = t.base + 58'(k);
      check($sformatf("v%0d_addr%0d", v, k), 512'(wq[k]), 512'(ea));
      check($sformatf("v%0d_data%0d", v, k), dq[k], line_data(v, k));
    end
    if (wq.size() > 0) begin
      check($sformatf("v%0d_last_addr", v), 512'(wq[wq.size()-1]), 512'(t.exp_last_addr));
    end
    mon_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            base                 n   hold fin  rst  wr  ov   last addr
    vecs[0] = '{58'h100,              5,  1'b0, 1'b0, 1'b1, 5,  1'b0, 58'h104};
    vecs[1] = '{58'h3FF_FFFF_FFFF_FFFF, 2, 1'b0, 1'b0, 1'b0, 2,  1'b0, 58'h0};
    vecs[2] = '{58'h2000,             17, 1'b1, 1'b0, 1'b0, 16, 1'b1, 58'h200F};
    vecs[3] = '{58'h55,               3,  1'b0, 1'b1, 1'b0, 3,  1'b0, 58'h57};
    vecs[4] = '{58'h1000,             14, 1'b1, 1'b0, 1'b0, 14, 1'b0, 58'h100D};
    vecs[5] = '{58'h9000,             2,  1'b0, 1'b0, 1'b0, 2,  1'b0, 58'h9001};

    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.base_addr      = '0;
    bus.output_request = 1'b0;
    bus.output_data    = '0;
    bus.output_valid   = 1'b0;
    bus.output_finish  = 1'b0;
    bus.wr_req_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      run_batch(v);
      @(posedge clk); #1;
    end

    // Reset with three lines buffered and the host not accepting.
    bus.start        = 1'b1;
    bus.base_addr    = 58'h7000;
    bus.wr_req_ready = 1'b0;
    @(posedge clk); #1;
    bus.start          = 1'b0;
    bus.output_request = 1'b1;
    @(posedge clk); #1;
    bus.output_request = 1'b0;
    check("midrst_permit", 512'(bus.output_permit), 512'(1'b1));
    for (int k = 0; k < 3; k++) begin
      bus.output_valid = 1'b1;
      bus.output_data  = line_data(9, k);
      @(posedge clk); #1;
    end
    bus.output_valid = 1'b0;
    check("midrst_buffered", 512'(bus.wr_req_valid), 512'(1'b1));
    check("midrst_addr", 512'(bus.wr_req_addr), 512'(58'h7000));
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    reset = 1'b0;
    bus.wr_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_no_request", 512'(bus.wr_req_valid), '0);
    run_batch(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
